dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
Control sequencer for one DSP multiply-accumulate slice. The slice is built from the team's registered-or-bypass stages on A/B, M and P.
- Accepts a vector length and a stream of operand-valid handshakes.
- Drives the slice clock enables, P-register reset and opmode so the slice computes P = sum(A[i]*B[i]) over the vector.
- Captures the final P into a result register with a valid/ready output handshake.
- Operand data goes straight from the source to the slice A/B ports; this block handles timing and control only.

Parameters:
LEN_W, 8, width of vector length and element counter
ABREG, 1, 1 = slice A/B inputs registered (sel=1), 0 = bypassed
MREG, 1, 1 = slice multiplier output registered, 0 = bypassed
P_W, 48, width of slice P output and result
OPMODE_FIRST, 8'h01, opmode for the first product: P = M
OPMODE_ACC, 8'h09, opmode for later products: P = P + M

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a job; sampled only in IDLE
len  in  LEN_W  number of products; captured on accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  source has an A/B operand pair on the slice ports
in_ready  out  1  sequencer accepts the operand pair this cycle
ce_ab  out  1  slice A/B register clock enable
ce_m  out  1  slice M register clock enable
ce_p  out  1  slice P register clock enable
rst_p  out  1  slice P register synchronous clear
opmode  out  8  slice opmode
p_in  in  P_W  slice P output
result  out  P_W  captured final accumulation
result_valid  out  1  result available
result_ready  in  1  consumer takes result

Behaviour:
- Reset (async) sets:
  - state = IDLE; counter = 0; stage-valid pipe = 0.
  - result = 0; result_valid = 0; busy = 0; in_ready = 0.
  - ce_ab = ce_m = ce_p = 0; opmode = OPMODE_ACC.
  - rst_p = 1 while rst is high.
- Reset mid-job: the job is abandoned and no result is produced.
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: capture len, go to CLEAR.
  - start=1 and len=0: ignored, stay IDLE.
- CLEAR: exactly one cycle, rst_p=1 (clears stale P), then go to ACCUM.
- ACCUM:
  - in_ready = (counter < len_q).
  - accept = in_valid & in_ready; counter increments on each accept.
  - Once counter reaches len_q, go to DRAIN.
  - in_valid=0 stalls; nothing advances except the in-flight pipe.
- Pipeline tracking:
  - Latency L = ABREG + MREG + 1 cycles from accept to the cycle in which ce_p is asserted... (ce_p cycle = accept cycle + L - 1).
  - A valid bit and a "first" tag (counter==0 at accept) shift through an (L-1)-deep pipe.
  - ce_ab = accept.
  - ce_m = valid at the M-stage input: accept if ABREG=0, otherwise pipe stage 1.
  - ce_p = valid at the P-stage input.
  - If ABREG=0, ce_ab is still driven but unused. If MREG=0, ce_m = ce_p.
  - opmode = OPMODE_FIRST in the cycle ce_p=1 with first tag=1, otherwise OPMODE_ACC.
- Gaps: bubbles between accepts give ce=0 cycles; the slice holds its registers and the sum is unaffected.
- DRAIN: wait until all pipe valid bits are 0. In that cycle, load result <= p_in, then go to DONE.
- Timing from the last accept cycle a: final ce_p at a+L-1, capture at a+L, result_valid=1 from cycle a+L+1.
- DONE:
  - result_valid=1; result is stable.
  - result_valid & result_ready: go to IDLE, result_valid=0 next cycle.
  - start in the same cycle as the handshake is ignored.
- Arithmetic: the sum is the slice's P_W-bit two's-complement wrap. No saturation and no overflow flag.
- start while busy: ignored. len changes while busy: ignored (len_q is used).
- in_valid outside ACCUM: ignored; in_ready=0.

Test Plan:
- ABREG=1, MREG=1, len=3, bench DSP model, operands (2,3),(4,5),(-1,7) back-to-back -> ce_ab on cycles a0..a0+2, ce_p on a0+2..a0+4, opmode 8'h01 then 8'h09 twice, result=19, result_valid at a0+2+4.
- Same job with in_valid bubbles of 1 and 3 cycles between operands -> result=19; ce_p count=3; no ce_p during bubbles.
- Back-to-back jobs with result_ready held low 5 cycles -> result_valid and result stable throughout; second job's CLEAR pulses rst_p; second result independent of first.
- start with len=0, and start while busy -> no state change, busy unchanged, no in_ready.
- Async rst asserted mid-ACCUM after 2 accepts -> all outputs at reset values immediately; next job len=1, operands (6,7) -> result=42.
- ABREG=0, MREG=0 (L=1), len=2, operands (3,3),(4,4) -> ce_p in the same cycle as accept, result=25, result_valid at last accept+2.

Source files
------------

// File: rtl/dsp_mac_sequencer_if.sv
// Bundle of control, handshake and slice-facing signals for dsp_mac_sequencer.
// The master side is the environment (job source, operand source, slice P
// output, result consumer). The slave side is the sequencer itself.
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int P_W   = 48
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic             ce_ab;
  logic             ce_m;
  logic             ce_p;
  logic             rst_p;
  logic [7:0]       opmode;
  logic [P_W-1:0]   p_in;
  logic [P_W-1:0]   result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output start, len, in_valid, p_in, result_ready,
    input  busy, in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, result, result_valid
  );

  modport slave (
    input  start, len, in_valid, p_in, result_ready,
    output busy, in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, result, result_valid
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for one DSP multiply-accumulate slice. Tracks each accepted
// operand pair through the slice's optional A/B and M registers so the P stage
// is enabled exactly once per product, with P = M for the first product and
// P = P + M afterwards. The final P is captured into a result register that is
// handed off with a valid/ready handshake.
module dsp_mac_sequencer #(
  parameter int         LEN_W        = 8,
  parameter int         ABREG        = 1,
  parameter int         MREG         = 1,
  parameter int         P_W          = 48,
  parameter logic [7:0] OPMODE_FIRST = 8'h01,
  parameter logic [7:0] OPMODE_ACC   = 8'h09
) (
  input logic                 clk,
  input logic                 rst,
  dsp_mac_sequencer_if.slave  bus
);

  // Number of register stages between the A/B ports and the P-stage input.
  localparam int PD = ABREG + MREG;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_q_reg;
  logic [LEN_W-1:0] count_reg;
  logic [P_W-1:0]   result_reg;

  logic in_ready_int;
  logic accept;
  logic last_accept;
  logic first_tag;
  logic m_valid;
  logic valid_at_p;
  logic first_at_p;
  logic pipe_empty;

  assign in_ready_int = (state_reg == ACCUM) && (count_reg < len_q_reg);
  assign accept       = in_ready_int && bus.in_valid;
  assign last_accept  = accept && ((count_reg + 1'b1) == len_q_reg);
  assign first_tag    = (count_reg == '0);

  generate
    if (PD == 0) begin : g_nopipe
      // Fully bypassed slice: the product reaches P in the accept cycle.
      assign m_valid    = accept;
      assign valid_at_p = accept;
      assign first_at_p = accept && first_tag;
      assign pipe_empty = 1'b1;
    end else begin : g_pipe
      logic [PD-1:0] vpipe_reg, vpipe_next;
      logic [PD-1:0] fpipe_reg, fpipe_next;

      assign vpipe_next[0] = accept;
      assign fpipe_next[0] = accept && first_tag;
      for (genvar gi = 1; gi < PD; gi++) begin : g_stage
        assign vpipe_next[gi] = vpipe_reg[gi-1];
        assign fpipe_next[gi] = fpipe_reg[gi-1];
      end

      // Shift valid and first-product tags alongside the operands in the slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vpipe_reg <= '0;
          fpipe_reg <= '0;
        end else begin
          vpipe_reg <= vpipe_next;
          fpipe_reg <= fpipe_next;
        end
      end

      // With bypassed A/B the M stage sees the operands in the accept cycle.
      assign m_valid    = (ABREG == 0) ? accept : vpipe_reg[0];
      assign valid_at_p = vpipe_reg[PD-1];
      assign first_at_p = fpipe_reg[PD-1];
      assign pipe_empty = (vpipe_reg == '0);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start && (bus.len != '0)) state_next = CLEAR;
      CLEAR:   state_next = ACCUM;
      ACCUM:   if (last_accept) state_next = DRAIN;
      DRAIN:   if (pipe_empty) state_next = DONE;
      DONE:    if (bus.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: slice enables, P clear, opmode and handshake flags.
  always_comb begin
    bus.busy         = (state_reg != IDLE);
    bus.in_ready     = in_ready_int;
    bus.ce_ab        = accept;
    bus.ce_m         = m_valid;
    bus.ce_p         = valid_at_p;
    bus.rst_p        = rst || (state_reg == CLEAR);
    bus.opmode       = (valid_at_p && first_at_p) ? OPMODE_FIRST : OPMODE_ACC;
    bus.result_valid = (state_reg == DONE);
    bus.result       = result_reg;
  end

  // Job length capture and element counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q_reg <= '0;
      count_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start && (bus.len != '0)) begin
      len_q_reg <= bus.len;
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Capture the final P once every in-flight product has been accumulated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    result_reg <= '0;
    else if ((state_reg == DRAIN) && pipe_empty) result_reg <= bus.p_in;
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a fully registered instance (ABREG=1, MREG=1)
// and a fully bypassed one (ABREG=0, MREG=0), each driving a behavioural slice.
module tb_dsp_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  dsp_mac_sequencer_if #(.LEN_W(8), .P_W(48)) bus1 ();
  dsp_mac_sequencer_if #(.LEN_W(8), .P_W(48)) bus0 ();

  dsp_mac_sequencer #(.ABREG(1), .MREG(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  dsp_mac_sequencer #(.ABREG(0), .MREG(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  // Stimulus variables
  logic              st1 = 0, st0 = 0, iv1 = 0, iv0 = 0, rr1 = 0, rr0 = 0;
  logic [7:0]        len1 = 0, len0 = 0;
  logic signed [17:0] opa1 = 0, opb1 = 0, opa0 = 0, opb0 = 0;

  assign bus1.start = st1;  assign bus1.len = len1;  assign bus1.in_valid = iv1;
  assign bus1.result_ready = rr1;
  assign bus0.start = st0;  assign bus0.len = len0;  assign bus0.in_valid = iv0;
  assign bus0.result_ready = rr0;

  // Slice model, registered A/B and M
  logic signed [17:0] ar1, br1;
  logic signed [35:0] mr1;
  logic [47:0]        pr1;
  always @(posedge clk) begin
    if (bus1.ce_ab) begin ar1 <= opa1; br1 <= opb1; end
    if (bus1.ce_m) mr1 <= ar1 * br1;
    if (bus1.rst_p) pr1 <= '0;
    else if (bus1.ce_p) pr1 <= (bus1.opmode == 8'h01) ? {{12{mr1[35]}}, mr1}
                                                     : pr1 + {{12{mr1[35]}}, mr1};
  end
  assign bus1.p_in = pr1;

  // Slice model, fully bypassed
  logic signed [35:0] m0;
  logic [47:0]        pr0;
  assign m0 = opa0 * opb0;
  always @(posedge clk) begin
    if (bus0.rst_p) pr0 <= '0;
    else if (bus0.ce_p) pr0 <= (bus0.opmode == 8'h01) ? {{12{m0[35]}}, m0}
                                                     : pr0 + {{12{m0[35]}}, m0};
  end
  assign bus0.p_in = pr0;

  // Event recorders (cycle of each ce_ab / ce_p, opmode at ce_p, rst_p cycles)
  int ab1[64], p1[64], ab0[64], p0[64];
  logic [7:0] op1[64], op0[64];
  int n_ab1 = 0, n_p1 = 0, n_rst1 = 0, rv_cyc1 = 0, n_ab0 = 0, n_p0 = 0, rv_cyc0 = 0;
  logic rv_prev1 = 0, rv_prev0 = 0;
  always @(negedge clk) begin
    if (bus1.ce_ab) begin ab1[n_ab1 % 64] <= cyc; n_ab1 <= n_ab1 + 1; end
    if (bus1.ce_p) begin p1[n_p1 % 64] <= cyc; op1[n_p1 % 64] <= bus1.opmode; n_p1 <= n_p1 + 1; end
    if (bus1.rst_p) n_rst1 <= n_rst1 + 1;
    if (bus1.result_valid && !rv_prev1) rv_cyc1 <= cyc;
    rv_prev1 <= bus1.result_valid;
    if (bus0.ce_ab) begin ab0[n_ab0 % 64] <= cyc; n_ab0 <= n_ab0 + 1; end
    if (bus0.ce_p) begin p0[n_p0 % 64] <= cyc; op0[n_p0 % 64] <= bus0.opmode; n_p0 <= n_p0 + 1; end
    if (bus0.result_valid && !rv_prev0) rv_cyc0 <= cyc;
    rv_prev0 <= bus0.result_valid;
  end

  int st_cyc;

  task automatic do_start(input int w, input logic [7:0] l);
    st_cyc = cyc;
    if (w == 1) begin st1 = 1'b1; len1 = l; end
    else begin st0 = 1'b1; len0 = l; end
    @(posedge clk); #1;
    st1 = 1'b0; st0 = 1'b0;
  endtask

  task automatic send(input int w, input int a, input int b, input int gap);
    int t;
    repeat (gap) begin iv1 = 1'b0; iv0 = 1'b0; @(posedge clk); #1; end
    if (w == 1) begin opa1 = 18'(a); opb1 = 18'(b); iv1 = 1'b1; end
    else begin opa0 = 18'(a); opb0 = 18'(b); iv0 = 1'b1; end
    t = 0;
    while ((((w == 1) ? bus1.in_ready : bus0.in_ready) !== 1'b1) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 50) begin
      failures++;
      $display("FAIL send_timeout dut%0d: waited %0d cycles, required in_ready within 50", w, t);
    end
    @(posedge clk); #1;
    iv1 = 1'b0; iv0 = 1'b0;
  endtask

  task automatic wait_rv(input int w);
    int t;
    t = 0;
    while ((((w == 1) ? bus1.result_valid : bus0.result_valid) !== 1'b1) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL result_timeout dut%0d: waited %0d cycles, required result_valid within 100", w, t);
    end
    @(negedge clk); #1;
    $display("job dut%0d done result=%0d cycle=%0d", w,
             $signed((w == 1) ? bus1.result : bus0.result), cyc);
  endtask

  task automatic consume(input int w);
    if (w == 1) rr1 = 1'b1; else rr0 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0; rr0 = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({bus1.busy, bus1.in_ready, bus1.ce_ab, bus1.ce_m, bus1.ce_p, bus1.rst_p, bus1.result_valid} !== 7'b0000010) begin
      failures++;
      $display("FAIL reset_flags1 got=%b required=0000010",
               {bus1.busy, bus1.in_ready, bus1.ce_ab, bus1.ce_m, bus1.ce_p, bus1.rst_p, bus1.result_valid});
    end
    checks++;
    if (bus1.opmode !== 8'h09 || bus1.result !== 48'd0) begin
      failures++;
      $display("FAIL reset_op_res1 got opmode=%h result=%h required 09/0", bus1.opmode, bus1.result);
    end
    checks++;
    if ({bus0.busy, bus0.rst_p, bus0.result_valid} !== 3'b010 || bus0.opmode !== 8'h09) begin
      failures++;
      $display("FAIL reset_dut0 got=%b opmode=%h required=010/09", {bus0.busy, bus0.rst_p, bus0.result_valid}, bus0.opmode);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus1.rst_p !== 1'b0 || bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rst_p=%b busy=%b required 0/0", bus1.rst_p, bus1.busy);
    end
    @(posedge clk); #1;
    $display("reset done cycle=%0d", cyc);
  endtask

  task automatic test_back_to_back;
    int bab, bp, a0;
    logic [7:0] exp_op[3];
    exp_op[0] = 8'h01; exp_op[1] = 8'h09; exp_op[2] = 8'h09;
    bab = n_ab1; bp = n_p1;
    do_start(1, 8'd3);
    a0 = st_cyc + 2;
    send(1, 2, 3, 0); send(1, 4, 5, 0); send(1, -1, 7, 0);
    wait_rv(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ab1[(bab + i) % 64] != a0 + i) begin
        failures++;
        $display("FAIL b2b_ce_ab[%0d] got cycle %0d required %0d", i, ab1[(bab + i) % 64], a0 + i);
      end
      checks++;
      if (p1[(bp + i) % 64] != a0 + 2 + i || op1[(bp + i) % 64] !== exp_op[i]) begin
        failures++;
        $display("FAIL b2b_ce_p[%0d] got cycle %0d opmode %h required %0d/%h", i,
                 p1[(bp + i) % 64], op1[(bp + i) % 64], a0 + 2 + i, exp_op[i]);
      end
    end
    checks++;
    if (n_p1 - bp != 3) begin
      failures++;
      $display("FAIL b2b_ce_p_count got %0d required 3", n_p1 - bp);
    end
    checks++;
    if (rv_cyc1 != a0 + 6) begin
      failures++;
      $display("FAIL b2b_rv_cycle got %0d required %0d", rv_cyc1, a0 + 6);
    end
    checks++;
    if (bus1.result !== 48'd19) begin
      failures++;
      $display("FAIL b2b_result got %0d required 19", $signed(bus1.result));
    end
    consume(1);
    checks++;
    if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after_take got rv=%b busy=%b required 0/0", bus1.result_valid, bus1.busy);
    end
  endtask

  task automatic test_bubbles;
    int bab, bp, c;
    int exp_ab[3];
    bab = n_ab1; bp = n_p1;
    do_start(1, 8'd3);
    c = st_cyc;
    exp_ab[0] = c + 2; exp_ab[1] = c + 4; exp_ab[2] = c + 8;
    send(1, 2, 3, 0); send(1, 4, 5, 1); send(1, -1, 7, 3);
    wait_rv(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ab1[(bab + i) % 64] != exp_ab[i] || p1[(bp + i) % 64] != exp_ab[i] + 2) begin
        failures++;
        $display("FAIL bubble_timing[%0d] got ce_ab %0d ce_p %0d required %0d/%0d", i,
                 ab1[(bab + i) % 64], p1[(bp + i) % 64], exp_ab[i], exp_ab[i] + 2);
      end
    end
    checks++;
    if (n_p1 - bp != 3) begin
      failures++;
      $display("FAIL bubble_ce_p_count got %0d required 3", n_p1 - bp);
    end
    checks++;
    if (bus1.result !== 48'd19 || rv_cyc1 != c + 12) begin
      failures++;
      $display("FAIL bubble_result got %0d at cycle %0d required 19 at %0d", $signed(bus1.result), rv_cyc1, c + 12);
    end
    consume(1);
  endtask

  task automatic test_hold_and_second_job;
    int brst, bad;
    logic [47:0] exp_neg;
    exp_neg = -48'sd10;
    do_start(1, 8'd2);
    send(1, 1, 2, 0); send(1, 3, 4, 0);
    wait_rv(1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      st1 = (k == 2);
      len1 = 8'd7;
      @(posedge clk); #1;
      st1 = 1'b0;
      if (bus1.result_valid !== 1'b1 || bus1.result !== 48'd14 || bus1.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable got %0d unstable cycles required 0 (rv=%b result=%0d)", bad,
               bus1.result_valid, $signed(bus1.result));
    end
    consume(1);
    checks++;
    if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_take got rv=%b busy=%b required 0/0", bus1.result_valid, bus1.busy);
    end
    brst = n_rst1;
    do_start(1, 8'd1);
    send(1, 5, -2, 0);
    wait_rv(1);
    checks++;
    if (n_rst1 - brst != 1) begin
      failures++;
      $display("FAIL second_rst_p got %0d pulse cycles required 1", n_rst1 - brst);
    end
    checks++;
    if (bus1.result !== exp_neg) begin
      failures++;
      $display("FAIL second_result got %0d required -10", $signed(bus1.result));
    end
    consume(1);
  endtask

  task automatic test_ignored_start;
    int bp;
    iv1 = 1'b1;
    do_start(1, 8'd0);
    checks++;
    if (bus1.busy !== 1'b0 || bus1.in_ready !== 1'b0 || bus1.ce_ab !== 1'b0) begin
      failures++;
      $display("FAIL len0_start got busy=%b in_ready=%b ce_ab=%b required 0/0/0",
               bus1.busy, bus1.in_ready, bus1.ce_ab);
    end
    iv1 = 1'b0;
    bp = n_p1;
    do_start(1, 8'd2);
    do_start(1, 8'd5);
    checks++;
    if (bus1.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start got busy=%b required 1", bus1.busy);
    end
    send(1, 2, 2, 0); send(1, 3, 3, 0);
    iv1 = 1'b1;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b0 || bus1.ce_ab !== 1'b0) begin
      failures++;
      $display("FAIL drain_in_ready got in_ready=%b ce_ab=%b required 0/0", bus1.in_ready, bus1.ce_ab);
    end
    iv1 = 1'b0;
    wait_rv(1);
    checks++;
    if (bus1.result !== 48'd13 || n_p1 - bp != 2) begin
      failures++;
      $display("FAIL busy_start_result got %0d with %0d products required 13 with 2",
               $signed(bus1.result), n_p1 - bp);
    end
    consume(1);
  endtask

  task automatic test_async_reset;
    int bad;
    do_start(1, 8'd4);
    send(1, 9, 9, 0); send(1, 8, 8, 0);
    iv1 = 1'b1;
    #1; rst = 1'b1; #1;
    checks++;
    if ({bus1.busy, bus1.in_ready, bus1.ce_ab, bus1.ce_m, bus1.ce_p, bus1.rst_p, bus1.result_valid} !== 7'b0000010
        || bus1.opmode !== 8'h09 || bus1.result !== 48'd0) begin
      failures++;
      $display("FAIL midjob_reset got flags=%b opmode=%h result=%0d required 0000010/09/0",
               {bus1.busy, bus1.in_ready, bus1.ce_ab, bus1.ce_m, bus1.ce_p, bus1.rst_p, bus1.result_valid},
               bus1.opmode, $signed(bus1.result));
    end
    @(posedge clk); @(posedge clk); #1;
    iv1 = 1'b0; rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abandoned_job got %0d cycles with busy/result_valid required 0", bad);
    end
    do_start(1, 8'd1);
    send(1, 6, 7, 0);
    wait_rv(1);
    checks++;
    if (bus1.result !== 48'd42) begin
      failures++;
      $display("FAIL post_reset_result got %0d required 42", $signed(bus1.result));
    end
    consume(1);
  endtask

  task automatic test_bypass;
    int bab, bp, c;
    logic [7:0] exp_op[2];
    exp_op[0] = 8'h01; exp_op[1] = 8'h09;
    bab = n_ab0; bp = n_p0;
    do_start(0, 8'd2);
    c = st_cyc;
    send(0, 3, 3, 0); send(0, 4, 4, 0);
    wait_rv(0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ab0[(bab + i) % 64] != c + 2 + i || p0[(bp + i) % 64] != c + 2 + i || op0[(bp + i) % 64] !== exp_op[i]) begin
        failures++;
        $display("FAIL bypass_timing[%0d] got ce_ab %0d ce_p %0d opmode %h required %0d/%0d/%h", i,
                 ab0[(bab + i) % 64], p0[(bp + i) % 64], op0[(bp + i) % 64], c + 2 + i, c + 2 + i, exp_op[i]);
      end
    end
    checks++;
    if (bus0.result !== 48'd25 || rv_cyc0 != c + 5) begin
      failures++;
      $display("FAIL bypass_result got %0d at cycle %0d required 25 at %0d", $signed(bus0.result), rv_cyc0, c + 5);
    end
    consume(0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_hold_and_second_job();
    test_ignored_start();
    test_async_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
